mmu_accum_drain: RTL and testbench
==================================

// Module: mmu_accum_drain
// PURPOSE
//  Output stage directly downstream of the 3x3 systolic MMU. Consumes the column psums (acc0..acc2).
//  MMU columns emit one cycle apart (col0 first), so this block de-skews them into one row-aligned vector.
//  Each vector is added to, or overwrites, one entry of a small accumulator buffer.
//  A drain FSM streams stored rows to the activation/UB writeback stage over a valid/ready handshake.
// PARAMETERS
//  ACC_WIDTH   32  psum/accumulator width (signed two's complement)
//  NCOL        3   MMU columns; fixed to 3, elaboration error otherwise
//  DEPTH       8   accumulator entries (rows), power of two, >=2
//  ADDR_W      $clog2(DEPTH)  derived; do not override
// PORTS
//  clk           in   1          single clock, rising edge
//  rst           in   1          asynchronous, active-high reset
//  in_valid      in   1          col0 result valid this cycle (col1/col2 follow at +1/+2)
//  in_addr       in   ADDR_W     target entry, sampled with in_valid
//  in_accumulate in   1          1: entry += vector; 0: entry = vector
//  acc0_in       in   ACC_WIDTH  MMU column 0 psum
//  acc1_in       in   ACC_WIDTH  MMU column 1 psum
//  acc2_in       in   ACC_WIDTH  MMU column 2 psum
//  drain_start   in   1          pulse: begin draining
//  drain_base    in   ADDR_W     first entry to drain
//  drain_count   in   ADDR_W+1   entries to drain, 1..DEPTH
//  drain_clear   in   1          1: zero each entry once it is handshaken out
//  out_valid     out  1          out_* holds a row
//  out_ready     in   1          downstream accepts
//  out_addr      out  ADDR_W     entry index of the row on out_*
//  out_data0..2  out  ACC_WIDTH  row columns 0..2
//  busy          out  1          drain FSM not IDLE, or a write is in the de-skew pipe
//  sat_flag      out  1          sticky: a saturation occurred
//  hazard_flag   out  1          sticky: write landed on an entry inside the active drain window
//  flags_clear   in   1          clears both sticky flags (set wins when in the same cycle)
// BEHAVIOUR
//  Reset: every output 0, all buffer entries 0, FSM IDLE, de-skew pipe empty.
//  Reset asserted mid-drain or mid-write aborts the operation; no partial row is presented afterwards.
//  De-skew: acc0 delayed 2 regs, acc1 delayed 1, acc2 delayed 0. in_valid/addr/accumulate travel with acc0.
//  The aligned vector exists at cycle T+2 for in_valid at T. The buffer entry updates at the T+3 edge.
//  A read issued at T+3 or later sees the new value.
//  A write is accepted every cycle, back-to-back; no backpressure on the MMU side.
//  Arithmetic: signed ACC_WIDTH add per column, saturating to max/min. Any saturating column sets sat_flag.
//  Overwrite (in_accumulate=0) never saturates.
//  Back-to-back writes to the same addr: the second must see the first's result.
//  Forward from the write stage; no lost update.
//  Drain FSM has three states:
//   IDLE: drain_start && drain_count!=0 -> latch base and count -> READ.
//         drain_start with count 0 is ignored. drain_start outside IDLE is ignored.
//   READ: registered buffer read of current addr -> PRESENT (1 cycle).
//   PRESENT: out_valid=1, out_addr and out_data stable until out_valid&&out_ready.
//         On handshake: if drain_clear, zero the entry; decrement remaining; addr = (addr+1) mod DEPTH.
//         Then -> READ if remaining!=0, else -> IDLE.
//  Latency and throughput: drain_start at D gives out_valid at D+2 (ready held high). One row per 2 cycles.
//  Address wrap: drain_base=DEPTH-1, count=2 drains DEPTH-1 then 0.
//  Write vs drain: if a write updates the entry currently in PRESENT, out_data is not refreshed.
//  Any write to an entry in the not-yet-handshaken drain window sets hazard_flag; the write is still performed.
//  Write and clear on the same entry, same cycle: the write wins (clear discarded).
//  busy: high from in_valid until its buffer update, and whenever the FSM is not IDLE.
// STRUCTURE
//  Shared package tpu_pkg: ACC_WIDTH default, sat_add() function, drain_state_e {IDLE,READ,PRESENT}.
//  One sub-module: mmu_deskew (per-column delay lines plus tag pipe; outputs aligned vector and tag).
//  Buffer is a flop array (DEPTH x NCOL x ACC_WIDTH), reset to 0.
// TESTING
//  1. acc0=1@T, acc1=2@T+1, acc2=3@T+2, in_valid@T, addr=0, accumulate=0; drain 1
//     -> out row0 = {1,2,3}, out_valid at D+2.
//  2. Same addr 5 written three back-to-back cycles with accumulate=1, data 10/20/30 per column
//     -> drained row5 = {60,60,60}; tests the forwarding path.
//  3. entry=0x7FFFFFF0 + 0x20 -> 0x7FFFFFFF and sat_flag=1.
//     Then flags_clear -> sat_flag=0. Negative case saturates to 0x80000000.
//  4. drain_base=7, count=3, drain_clear=1, out_ready toggling 1/0
//     -> addrs 7,0,1 in order, data stable while stalled, entries read 0 afterwards.
//  5. drain_start during PRESENT, plus count=0 in IDLE
//     -> both ignored; a write to a pending drain addr -> hazard_flag=1.
//  6. rst pulsed while out_valid=1 and a write is in the pipe
//     -> all outputs 0, FSM IDLE, buffer all 0, no later out_valid.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the MMU output stage: accumulator width, drain FSM encoding
// and the signed saturating adder used by the accumulator write stage.
package tpu_pkg;

    localparam int ACC_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2
    } drain_state_e;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               sat;
    } sat_res_t;

    // Operands arrive sign-extended to 64 bits; w is the real width (<= 63) to clamp at.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned        w);
        sat_res_t           r;
        logic signed [63:0] s;
        logic signed [63:0] lim_hi;
        logic signed [63:0] lim_lo;
        s      = a + b;
        lim_hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lim_lo = -lim_hi - 64'sd1;
        if (s > lim_hi) begin
            r.sum = lim_hi;
            r.sat = 1'b1;
        end else if (s < lim_lo) begin
            r.sum = lim_lo;
            r.sat = 1'b1;
        end else begin
            r.sum = s;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mmu_accum_drain_if.sv
// Bundle of the MMU psum input, drain control, writeback stream and status signals.
interface mmu_accum_drain_if #(
    parameter int ACC_WIDTH = 32,
    parameter int DEPTH     = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                 in_valid;
    logic [ADDR_W-1:0]    in_addr;
    logic                 in_accumulate;
    logic [ACC_WIDTH-1:0] acc0_in;
    logic [ACC_WIDTH-1:0] acc1_in;
    logic [ACC_WIDTH-1:0] acc2_in;
    logic                 drain_start;
    logic [ADDR_W-1:0]    drain_base;
    logic [ADDR_W:0]      drain_count;
    logic                 drain_clear;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_W-1:0]    out_addr;
    logic [ACC_WIDTH-1:0] out_data0;
    logic [ACC_WIDTH-1:0] out_data1;
    logic [ACC_WIDTH-1:0] out_data2;
    logic                 busy;
    logic                 sat_flag;
    logic                 hazard_flag;
    logic                 flags_clear;

    modport master (
        output in_valid, in_addr, in_accumulate, acc0_in, acc1_in, acc2_in,
               drain_start, drain_base, drain_count, drain_clear, out_ready, flags_clear,
        input  out_valid, out_addr, out_data0, out_data1, out_data2, busy, sat_flag, hazard_flag
    );

    modport slave (
        input  in_valid, in_addr, in_accumulate, acc0_in, acc1_in, acc2_in,
               drain_start, drain_base, drain_count, drain_clear, out_ready, flags_clear,
        output out_valid, out_addr, out_data0, out_data1, out_data2, busy, sat_flag, hazard_flag
    );

endinterface

// File: rtl/mmu_deskew.sv
// Realigns the staggered MMU column outputs (col0 first) into one row vector; the write
// tag (valid/addr/accumulate) rides along with column 0.
module mmu_deskew
    import tpu_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_W_DEF,
    parameter int ADDR_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic                 i_accumulate,
    input  logic [ACC_WIDTH-1:0] i_acc0,
    input  logic [ACC_WIDTH-1:0] i_acc1,
    input  logic [ACC_WIDTH-1:0] i_acc2,
    output logic                 o_valid,
    output logic [ADDR_W-1:0]    o_addr,
    output logic                 o_accumulate,
    output logic [ACC_WIDTH-1:0] o_vec0,
    output logic [ACC_WIDTH-1:0] o_vec1,
    output logic [ACC_WIDTH-1:0] o_vec2,
    output logic                 o_busy
);

    logic [ACC_WIDTH-1:0] r_a0_d1;
    logic [ACC_WIDTH-1:0] r_a0_d2;
    logic [ACC_WIDTH-1:0] r_a1_d1;
    logic                 r_v_d1;
    logic                 r_v_d2;
    logic [ADDR_W-1:0]    r_addr_d1;
    logic [ADDR_W-1:0]    r_addr_d2;
    logic                 r_accm_d1;
    logic                 r_accm_d2;

    // Column delay lines and tag pipe; column 2 is already aligned and passes straight through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a0_d1   <= '0;
            r_a0_d2   <= '0;
            r_a1_d1   <= '0;
            r_v_d1    <= 1'b0;
            r_v_d2    <= 1'b0;
            r_addr_d1 <= '0;
            r_addr_d2 <= '0;
            r_accm_d1 <= 1'b0;
            r_accm_d2 <= 1'b0;
        end else begin
            r_a0_d1   <= i_acc0;
            r_a0_d2   <= r_a0_d1;
            r_a1_d1   <= i_acc1;
            r_v_d1    <= i_valid;
            r_v_d2    <= r_v_d1;
            r_addr_d1 <= i_addr;
            r_addr_d2 <= r_addr_d1;
            r_accm_d1 <= i_accumulate;
            r_accm_d2 <= r_accm_d1;
        end
    end

    assign o_valid      = r_v_d2;
    assign o_addr       = r_addr_d2;
    assign o_accumulate = r_accm_d2;
    assign o_vec0       = r_a0_d2;
    assign o_vec1       = r_a1_d1;
    assign o_vec2       = i_acc2;
    assign o_busy       = r_v_d1 | r_v_d2;

endmodule

// File: rtl/mmu_accum_drain.sv
// MMU output stage: de-skewed psum rows are accumulated into a small flop buffer and a
// drain FSM streams stored rows to writeback over valid/ready.
module mmu_accum_drain
    import tpu_pkg::*;
#(
    parameter  int ACC_WIDTH = ACC_W_DEF,
    parameter  int NCOL      = 3,
    parameter  int DEPTH     = 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    mmu_accum_drain_if.slave bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_READ    = READ;
    localparam logic [1:0] S_PRESENT = PRESENT;

    if (NCOL != 3) begin : g_ncol_chk
        $error("mmu_accum_drain: NCOL must be 3");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("mmu_accum_drain: DEPTH must be a power of two >= 2");
    end

    logic                        w_wr_vld;
    logic [ADDR_W-1:0]           w_wr_addr;
    logic                        w_wr_acc;
    logic [ACC_WIDTH-1:0]        w_vec0;
    logic [ACC_WIDTH-1:0]        w_vec1;
    logic [ACC_WIDTH-1:0]        w_vec2;
    logic                        w_pipe_busy;
    logic signed [ACC_WIDTH-1:0] w_vec [NCOL];
    logic signed [ACC_WIDTH-1:0] w_new [NCOL];
    logic                        w_sat_any;
    sat_res_t                    w_res;
    logic [ADDR_W-1:0]           w_offset;
    logic                        w_in_window;
    logic                        w_hs;
    logic                        w_clr;

    logic signed [ACC_WIDTH-1:0] r_buf [DEPTH][NCOL];
    logic [1:0]                  r_state;
    logic [ADDR_W-1:0]           r_addr;
    logic [ADDR_W:0]             r_remaining;
    logic [ADDR_W-1:0]           r_out_addr;
    logic [ACC_WIDTH-1:0]        r_out_data [NCOL];
    logic                        r_sat_flag;
    logic                        r_hazard_flag;

    mmu_deskew #(
        .ACC_WIDTH (ACC_WIDTH),
        .ADDR_W    (ADDR_W)
    ) u_deskew (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (bus.in_valid),
        .i_addr       (bus.in_addr),
        .i_accumulate (bus.in_accumulate),
        .i_acc0       (bus.acc0_in),
        .i_acc1       (bus.acc1_in),
        .i_acc2       (bus.acc2_in),
        .o_valid      (w_wr_vld),
        .o_addr       (w_wr_addr),
        .o_accumulate (w_wr_acc),
        .o_vec0       (w_vec0),
        .o_vec1       (w_vec1),
        .o_vec2       (w_vec2),
        .o_busy       (w_pipe_busy)
    );

    assign w_vec[0] = w_vec0;
    assign w_vec[1] = w_vec1;
    assign w_vec[2] = w_vec2;

    // Read-modify-write in one cycle: a back-to-back write to the same entry reads the value
    // committed at the previous edge, so no separate bypass is needed.
    always_comb begin
        w_sat_any = 1'b0;
        w_res     = '0;
        for (int c = 0; c < NCOL; c++) begin
            w_new[c] = w_vec[c];
            if (w_wr_acc) begin
                w_res    = sat_add(64'(r_buf[w_wr_addr][c]), 64'(w_vec[c]), int'(ACC_WIDTH));
                w_new[c] = w_res.sum[ACC_WIDTH-1:0];
                if (w_res.sat) begin
                    w_sat_any = 1'b1;
                end else begin
                    w_sat_any = w_sat_any;
                end
            end else begin
                w_new[c] = w_vec[c];
            end
        end
    end

    // Pending drain window is [r_addr, r_addr + r_remaining) modulo DEPTH.
    assign w_offset    = w_wr_addr - r_addr;
    assign w_in_window = (r_state != S_IDLE) && ({1'b0, w_offset} < r_remaining);
    assign w_hs        = (r_state == S_PRESENT) && bus.out_ready;
    assign w_clr       = w_hs && bus.drain_clear;

    // Accumulator buffer; a landing write takes priority over a drain clear of the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int c = 0; c < NCOL; c++) begin
                    r_buf[i][c] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_vld && (w_wr_addr == ADDR_W'(i))) begin
                    for (int c = 0; c < NCOL; c++) begin
                        r_buf[i][c] <= w_new[c];
                    end
                end else if (w_clr && (r_addr == ADDR_W'(i))) begin
                    for (int c = 0; c < NCOL; c++) begin
                        r_buf[i][c] <= '0;
                    end
                end
            end
        end
    end

    // Drain FSM: IDLE -> READ (registered fetch) -> PRESENT (hold until handshake).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_out_addr  <= '0;
            for (int c = 0; c < NCOL; c++) begin
                r_out_data[c] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.drain_start && (bus.drain_count != '0)) begin
                        r_addr      <= bus.drain_base;
                        r_remaining <= bus.drain_count;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    for (int c = 0; c < NCOL; c++) begin
                        r_out_data[c] <= r_buf[r_addr][c];
                    end
                    r_out_addr <= r_addr;
                    r_state    <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (bus.out_ready) begin
                        r_remaining <= r_remaining - (ADDR_W + 1)'(1);
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_state     <= (r_remaining == (ADDR_W + 1)'(1)) ? S_IDLE : S_READ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky status; a set in the same cycle as flags_clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_flag    <= 1'b0;
            r_hazard_flag <= 1'b0;
        end else begin
            if (w_wr_vld && w_wr_acc && w_sat_any) begin
                r_sat_flag <= 1'b1;
            end else if (bus.flags_clear) begin
                r_sat_flag <= 1'b0;
            end
            if (w_wr_vld && w_in_window) begin
                r_hazard_flag <= 1'b1;
            end else if (bus.flags_clear) begin
                r_hazard_flag <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = (r_state == S_PRESENT);
    assign bus.out_addr    = r_out_addr;
    assign bus.out_data0   = r_out_data[0];
    assign bus.out_data1   = r_out_data[1];
    assign bus.out_data2   = r_out_data[2];
    assign bus.busy        = bus.in_valid | w_pipe_busy | (r_state != S_IDLE);
    assign bus.sat_flag    = r_sat_flag;
    assign bus.hazard_flag = r_hazard_flag;

endmodule

// File: tb/tb_mmu_accum_drain.sv
// Directed bench for mmu_accum_drain: de-skew, accumulate/forward, saturation, drain
// handshake with wrap/clear/stall, ignored starts, hazard flag and mid-operation reset.
module tb_mmu_accum_drain;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [2:0]  v_addr [4];
    logic        v_acc  [4];
    logic [31:0] v_d    [4][3];

    mmu_accum_drain_if #(.ACC_WIDTH(32), .DEPTH(8)) bus ();

    mmu_accum_drain #(.ACC_WIDTH(32), .NCOL(3), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int k, input logic [2:0] a, input logic acc,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        v_addr[k]  = a;
        v_acc[k]   = acc;
        v_d[k][0]  = d0;
        v_d[k][1]  = d1;
        v_d[k][2]  = d2;
    endtask

    // Drives n vectors back-to-back with the MMU column skew; returns after the last lands.
    task automatic mmu_send(input int n);
        for (int cyc = 0; cyc < n + 2; cyc++) begin
            bus.in_valid      = (cyc < n);
            bus.in_addr       = (cyc < n) ? v_addr[cyc] : 3'd0;
            bus.in_accumulate = (cyc < n) ? v_acc[cyc] : 1'b0;
            bus.acc0_in       = (cyc < n) ? v_d[cyc][0] : 32'd0;
            bus.acc1_in       = (cyc >= 1 && cyc - 1 < n) ? v_d[cyc-1][1] : 32'd0;
            bus.acc2_in       = (cyc >= 2 && cyc - 2 < n) ? v_d[cyc-2][2] : 32'd0;
            tick();
        end
        bus.in_valid      = 1'b0;
        bus.in_addr       = 3'd0;
        bus.in_accumulate = 1'b0;
        bus.acc0_in       = 32'd0;
        bus.acc1_in       = 32'd0;
        bus.acc2_in       = 32'd0;
    endtask

    task automatic pulse_start(input logic [2:0] base, input logic [3:0] cnt, input logic clr);
        bus.drain_start = 1'b1;
        bus.drain_base  = base;
        bus.drain_count = cnt;
        bus.drain_clear = clr;
        tick();
        bus.drain_start = 1'b0;
    endtask

    task automatic expect_row(input string tag, input logic [2:0] a,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        bus.out_ready = 1'b1;
        pulse_start(a, 4'd1, 1'b0);
        check_val({tag, "_v_d1"}, 64'(bus.out_valid), 64'd0);
        tick();
        check_val({tag, "_v_d2"}, 64'(bus.out_valid), 64'd1);
        check_val({tag, "_addr"}, 64'(bus.out_addr), 64'(a));
        check_val({tag, "_d0"}, 64'(bus.out_data0), 64'(e0));
        check_val({tag, "_d1"}, 64'(bus.out_data1), 64'(e1));
        check_val({tag, "_d2"}, 64'(bus.out_data2), 64'(e2));
        tick();
        check_val({tag, "_done"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (!bus.out_valid && w < 8) begin
            tick();
            w++;
        end
        check_val({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_addr = 3'd0; bus.in_accumulate = 1'b0;
        bus.acc0_in = 32'd0; bus.acc1_in = 32'd0; bus.acc2_in = 32'd0;
        bus.drain_start = 1'b0; bus.drain_base = 3'd0; bus.drain_count = 4'd0;
        bus.drain_clear = 1'b0; bus.out_ready = 1'b1; bus.flags_clear = 1'b0;
        for (int k = 0; k < 4; k++) set_vec(k, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);

        repeat (3) tick();
        check_val("rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_sat", 64'(bus.sat_flag), 64'd0);
        check_val("rst_haz", 64'(bus.hazard_flag), 64'd0);
        check_val("rst_data0", 64'(bus.out_data0), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single skewed vector into entry 0
        set_vec(0, 3'd0, 1'b0, 32'd1, 32'd2, 32'd3);
        mmu_send(1);
        check_val("t1_idle_busy", 64'(bus.busy), 64'd0);
        expect_row("t1_row0", 3'd0, 32'd1, 32'd2, 32'd3);

        // 2: three back-to-back accumulates to entry 5
        set_vec(0, 3'd5, 1'b1, 32'd10, 32'd10, 32'd10);
        set_vec(1, 3'd5, 1'b1, 32'd20, 32'd20, 32'd20);
        set_vec(2, 3'd5, 1'b1, 32'd30, 32'd30, 32'd30);
        mmu_send(3);
        expect_row("t2_row5", 3'd5, 32'd60, 32'd60, 32'd60);

        // 3: positive saturation, flag clear, overwrite never saturates, negative saturation
        set_vec(0, 3'd2, 1'b0, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'd5);
        mmu_send(1);
        check_val("t3_sat_pre", 64'(bus.sat_flag), 64'd0);
        set_vec(0, 3'd2, 1'b1, 32'h20, 32'h10, 32'd1);
        mmu_send(1);
        check_val("t3_sat_pos", 64'(bus.sat_flag), 64'd1);
        expect_row("t3_row2", 3'd2, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd6);
        bus.flags_clear = 1'b1;
        tick();
        bus.flags_clear = 1'b0;
        check_val("t3_sat_clr", 64'(bus.sat_flag), 64'd0);
        set_vec(0, 3'd3, 1'b0, 32'h80000010, 32'hFFFFFFFF, 32'h7FFFFFFF);
        mmu_send(1);
        check_val("t3_sat_ovw", 64'(bus.sat_flag), 64'd0);
        set_vec(0, 3'd3, 1'b1, 32'hFFFFFFE0, 32'hFFFFFFFF, 32'd0);
        mmu_send(1);
        check_val("t3_sat_neg", 64'(bus.sat_flag), 64'd1);
        expect_row("t3_row3", 3'd3, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF);

        // 4: wrapping drain 7,0,1 with clear and stalls
        set_vec(0, 3'd7, 1'b0, 32'd70, 32'd71, 32'd72);
        set_vec(1, 3'd1, 1'b0, 32'd11, 32'd12, 32'd13);
        mmu_send(2);
        bus.out_ready = 1'b0;
        pulse_start(3'd7, 4'd3, 1'b1);
        check_val("t4_busy", 64'(bus.busy), 64'd1);
        for (int r = 0; r < 3; r++) begin
            logic [2:0]  ea;
            logic [31:0] e0;
            ea = (r == 0) ? 3'd7 : ((r == 1) ? 3'd0 : 3'd1);
            e0 = (r == 0) ? 32'd70 : ((r == 1) ? 32'd1 : 32'd11);
            wait_valid("t4");
            check_val("t4_addr", 64'(bus.out_addr), 64'(ea));
            check_val("t4_data0", 64'(bus.out_data0), 64'(e0));
            tick();
            check_val("t4_stall_vld", 64'(bus.out_valid), 64'd1);
            check_val("t4_stall_addr", 64'(bus.out_addr), 64'(ea));
            check_val("t4_stall_data", 64'(bus.out_data0), 64'(e0));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        check_val("t4_end_vld", 64'(bus.out_valid), 64'd0);
        check_val("t4_end_busy", 64'(bus.busy), 64'd0);
        expect_row("t4_clr7", 3'd7, 32'd0, 32'd0, 32'd0);
        expect_row("t4_clr0", 3'd0, 32'd0, 32'd0, 32'd0);
        expect_row("t4_clr1", 3'd1, 32'd0, 32'd0, 32'd0);

        // 5: ignored starts and hazard detection
        pulse_start(3'd2, 4'd0, 1'b0);
        check_val("t5_cnt0_busy", 64'(bus.busy), 64'd0);
        tick();
        check_val("t5_cnt0_vld", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;
        pulse_start(3'd4, 4'd3, 1'b0);
        wait_valid("t5_first");
        pulse_start(3'd0, 4'd1, 1'b0);
        check_val("t5_ign_vld", 64'(bus.out_valid), 64'd1);
        check_val("t5_ign_addr", 64'(bus.out_addr), 64'd4);
        set_vec(0, 3'd3, 1'b0, 32'd33, 32'd33, 32'd33);
        mmu_send(1);
        check_val("t5_haz_out", 64'(bus.hazard_flag), 64'd0);
        set_vec(0, 3'd6, 1'b0, 32'd66, 32'd66, 32'd66);
        mmu_send(1);
        check_val("t5_haz_in", 64'(bus.hazard_flag), 64'd1);
        bus.out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            logic [31:0] e0;
            e0 = (r == 0) ? 32'd0 : ((r == 1) ? 32'd60 : 32'd66);
            wait_valid("t5");
            check_val("t5_addr", 64'(bus.out_addr), 64'(4 + r));
            check_val("t5_data2", 64'(bus.out_data2), 64'(e0));
            tick();
        end
        check_val("t5_end_vld", 64'(bus.out_valid), 64'd0);

        // 6: reset while presenting and with a write in the de-skew pipe
        bus.out_ready = 1'b0;
        pulse_start(3'd5, 4'd2, 1'b0);
        wait_valid("t6_pre");
        check_val("t6_haz_pre", 64'(bus.hazard_flag), 64'd1);
        bus.in_valid = 1'b1; bus.in_addr = 3'd0; bus.acc0_in = 32'd99;
        tick();
        bus.in_valid = 1'b0; bus.acc0_in = 32'd0; bus.acc1_in = 32'd99;
        rst = 1'b1;
        #1;
        bus.acc1_in = 32'd0;
        check_val("t6_vld", 64'(bus.out_valid), 64'd0);
        check_val("t6_addr", 64'(bus.out_addr), 64'd0);
        check_val("t6_data0", 64'(bus.out_data0), 64'd0);
        check_val("t6_busy", 64'(bus.busy), 64'd0);
        check_val("t6_sat", 64'(bus.sat_flag), 64'd0);
        check_val("t6_haz", 64'(bus.hazard_flag), 64'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("t6_no_vld", 64'(bus.out_valid), 64'd0);
        end
        expect_row("t6_row0", 3'd0, 32'd0, 32'd0, 32'd0);
        expect_row("t6_row5", 3'd5, 32'd0, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
